// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB completion stage.
// Consumers import this package to agree on FU_RESULT / CDB_PACKET layout.
package cdb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int PRN_WIDTH     = 6;
    localparam int ROB_CNT_WIDTH = 5;

    localparam int NUM_FU_ALU    = 1;
    localparam int NUM_FU_MULT   = 1;
    localparam int NUM_FU_LOAD   = 1;
    localparam int NUM_FU_STORE  = 1;
    localparam int N             = 2;

    localparam int NUM_REQ_DEF = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD + NUM_FU_STORE;

    typedef logic [ROB_CNT_WIDTH-1:0] ROBN;

    typedef struct packed {
        logic                 valid;
        logic [PRN_WIDTH-1:0] dest_prn;
        logic [XLEN-1:0]      value;
        ROBN                  robn;
    } FU_RESULT;

    typedef struct packed {
        logic                 valid;
        logic [PRN_WIDTH-1:0] dest_prn;
        logic [XLEN-1:0]      value;
    } CDB_PACKET;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_sel.sv
// Combinational rotated multi-grant selector (cdb_rr_sel): grants the first
// CDB_W requests found scanning upward from start_i, wrapping modulo NUM_REQ.
module cdb_rr_sel #(
    parameter int NUM_REQ = 4,
    parameter int CDB_W   = 2,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [PTR_W-1:0]              start_i,
    output logic [CDB_W-1:0][NUM_REQ-1:0] lane_gnt_o,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          any_gnt_o,
    output logic [PTR_W-1:0]              last_idx_o
);

    logic [2*NUM_REQ-1:0]            req_dbl;
    logic [NUM_REQ-1:0]              req_rot;
    logic [CDB_W-1:0][NUM_REQ-1:0]   lane_rot;
    int                              cnt;
    int                              last_k;
    int                              last_sum;

    // Rotate so that position 0 is the start index; the scan then uses constant indices.
    assign req_dbl = {req_i, req_i} >> start_i;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        lane_rot = '0;
        cnt      = 0;
        last_k   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_rot[k]) begin
                for (int j = 0; j < CDB_W; j++) begin
                    if (cnt == j) begin
                        lane_rot[j][k] = 1'b1;
                        last_k         = k;
                    end
                end
                if (cnt < CDB_W) cnt = cnt + 1;
            end
        end
    end

    for (genvar j = 0; j < CDB_W; j++) begin : g_unrot
        logic [2*NUM_REQ-1:0] dbl;
        assign dbl           = {lane_rot[j], lane_rot[j]} << start_i;
        assign lane_gnt_o[j] = dbl[2*NUM_REQ-1:NUM_REQ];
    end

    always_comb begin
        gnt_o = '0;
        for (int j = 0; j < CDB_W; j++) gnt_o = gnt_o | lane_gnt_o[j];
    end

    assign any_gnt_o = |req_i;

    always_comb begin
        last_sum = last_k + int'(start_i);
        if (last_sum >= NUM_REQ) last_sum = last_sum - NUM_REQ;
        last_idx_o = PTR_W'(last_sum);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to CDB_W finished FU results per cycle onto a
// registered broadcast bus. Define CDB_FIXED_PRIO_EN for static priority (index 0 highest).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CDB_W   = N,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  FU_RESULT  [NUM_REQ-1:0]      fu_result,
    output logic      [NUM_REQ-1:0]      fu_result_ready,
    output CDB_PACKET [CDB_W-1:0]        cdb_packet,
    output ROBN       [CDB_W-1:0]        cdb_robn
);

    logic [NUM_REQ-1:0]            req_live;
    logic [NUM_REQ-1:0]            req_zero;
    logic [CDB_W-1:0][NUM_REQ-1:0] lane_gnt;
    logic [NUM_REQ-1:0]            gnt;
    logic                          any_gnt;
    logic [PTR_W-1:0]              last_idx;
    logic [PTR_W-1:0]              start;

    CDB_PACKET [CDB_W-1:0] pkt_d,  pkt_q;
    ROBN       [CDB_W-1:0] robn_d, robn_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_live[i] = fu_result[i].valid && (fu_result[i].dest_prn != '0);
            req_zero[i] = fu_result[i].valid && (fu_result[i].dest_prn == '0);
        end
    end

    cdb_rr_sel #(
        .NUM_REQ (NUM_REQ),
        .CDB_W   (CDB_W),
        .PTR_W   (PTR_W)
    ) u_sel (
        .req_i      (req_live),
        .start_i    (start),
        .lane_gnt_o (lane_gnt),
        .gnt_o      (gnt),
        .any_gnt_o  (any_gnt),
        .last_idx_o (last_idx)
    );

`ifdef CDB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [PTR_W-1:0] rr_ptr_d, rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_gnt && !squash) begin
            rr_ptr_d = (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    assign start = rr_ptr_q;
`endif

    // Zero-register results are retired immediately; they never take a lane.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            fu_result_ready[i] = !reset && !squash && (gnt[i] || req_zero[i]);
        end
    end

    always_comb begin
        pkt_d  = '0;
        robn_d = '0;
        for (int j = 0; j < CDB_W; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!squash && lane_gnt[j][i]) begin
                    pkt_d[j].valid    = 1'b1;
                    pkt_d[j].dest_prn = fu_result[i].dest_prn;
                    pkt_d[j].value    = fu_result[i].value;
                    robn_d[j]         = fu_result[i].robn;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_q  <= '0;
            robn_q <= '0;
        end else begin
            pkt_q  <= pkt_d;
            robn_q <= robn_d;
        end
    end

    assign cdb_packet = pkt_q;
    assign cdb_robn   = robn_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (round-robin build, NUM_REQ=4, CDB_W=2).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int CW = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 squash;
    FU_RESULT  [NR-1:0]   fu_result;
    logic      [NR-1:0]   fu_result_ready;
    CDB_PACKET [CW-1:0]   cdb_packet;
    ROBN       [CW-1:0]   cdb_robn;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_REQ(NR), .CDB_W(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_result       (fu_result),
        .fu_result_ready (fu_result_ready),
        .cdb_packet      (cdb_packet),
        .cdb_robn        (cdb_robn)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [PRN_WIDTH-1:0] prn,
                           input logic [XLEN-1:0] val, input logic [ROB_CNT_WIDTH-1:0] rob);
        fu_result[i].valid    = v;
        fu_result[i].dest_prn = prn;
        fu_result[i].value    = val;
        fu_result[i].robn     = rob;
    endtask

    task automatic clr_all();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
    endtask

    task automatic lane_on(input string tag, input int j, input logic [PRN_WIDTH-1:0] prn,
                           input logic [XLEN-1:0] val, input logic [ROB_CNT_WIDTH-1:0] rob);
        chk({tag, ".v"},    64'(cdb_packet[j].valid),    64'(1'b1));
        chk({tag, ".prn"},  64'(cdb_packet[j].dest_prn), 64'(prn));
        chk({tag, ".val"},  64'(cdb_packet[j].value),    64'(val));
        chk({tag, ".robn"}, 64'(cdb_robn[j]),            64'(rob));
    endtask

    task automatic lane_off(input string tag, input int j);
        chk({tag, ".v"}, 64'(cdb_packet[j].valid), 64'(1'b0));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        squash = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, PRN_WIDTH'(i + 1), XLEN'(32'h50 + i), ROB_CNT_WIDTH'(i));
        #1;
        chk("rst_ready", 64'(fu_result_ready), 64'(4'b0000));
        tick();
        lane_off("rst_l0", 0);
        lane_off("rst_l1", 1);
        chk("rst_prn0",  64'(cdb_packet[0].dest_prn), 64'd0);
        chk("rst_robn0", 64'(cdb_robn[0]), 64'd0);
        reset = 1'b0;
        clr_all();
        tick();
        lane_off("idle_l0", 0);

        // single request on index 2 -> ptr 3
        set_req(2, 1'b1, 6'd5, 32'hDEAD, 5'd7);
        #1 chk("one_ready", 64'(fu_result_ready), 64'(4'b0100));
        tick();
        clr_all();
        lane_on("one_l0", 0, 6'd5, 32'hDEAD, 5'd7);
        lane_off("one_l1", 1);

        // wrap: ptr 3, requests 3 and 0 -> lane0=req3, lane1=req0, ptr 1
        set_req(3, 1'b1, 6'd10, 32'h33, 5'd3);
        set_req(0, 1'b1, 6'd11, 32'h100, 5'd0);
        #1 chk("wrap_ready", 64'(fu_result_ready), 64'(4'b1001));
        tick();
        clr_all();
        lane_on("wrap_l0", 0, 6'd10, 32'h33, 5'd3);
        lane_on("wrap_l1", 1, 6'd11, 32'h100, 5'd0);

        // lone req3 from ptr 1 -> ptr 0
        set_req(3, 1'b1, 6'd12, 32'h44, 5'd9);
        #1 chk("r3_ready", 64'(fu_result_ready), 64'(4'b1000));
        tick();
        clr_all();
        lane_on("r3_l0", 0, 6'd12, 32'h44, 5'd9);
        lane_off("r3_l1", 1);

        // all four valid, held until granted
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, PRN_WIDTH'(i + 1), XLEN'(32'hA0 + i), ROB_CNT_WIDTH'(i));
        #1 chk("all_a_ready", 64'(fu_result_ready), 64'(4'b0011));
        tick();
        lane_on("all_a_l0", 0, 6'd1, 32'hA0, 5'd0);
        lane_on("all_a_l1", 1, 6'd2, 32'hA1, 5'd1);
        set_req(0, 1'b1, 6'd21, 32'hB0, 5'd10);
        set_req(1, 1'b1, 6'd22, 32'hB1, 5'd11);
        #1 chk("all_b_ready", 64'(fu_result_ready), 64'(4'b1100));
        tick();
        lane_on("all_b_l0", 0, 6'd3, 32'hA2, 5'd2);
        lane_on("all_b_l1", 1, 6'd4, 32'hA3, 5'd3);
        set_req(2, 1'b1, 6'd23, 32'hC2, 5'd12);
        set_req(3, 1'b1, 6'd24, 32'hC3, 5'd13);
        #1 chk("all_c_ready", 64'(fu_result_ready), 64'(4'b0011));
        tick();
        clr_all();
        lane_on("all_c_l0", 0, 6'd21, 32'hB0, 5'd10);
        lane_on("all_c_l1", 1, 6'd22, 32'hB1, 5'd11);

        // ptr 2; req1 targets p0 -> retired without a lane
        set_req(0, 1'b1, 6'd7, 32'h70, 5'd1);
        set_req(1, 1'b1, 6'd0, 32'h99, 5'd4);
        set_req(2, 1'b1, 6'd8, 32'h80, 5'd2);
        #1 chk("p0_ready", 64'(fu_result_ready), 64'(4'b0111));
        tick();
        clr_all();
        lane_on("p0_l0", 0, 6'd8, 32'h80, 5'd2);
        lane_on("p0_l1", 1, 6'd7, 32'h70, 5'd1);

        // squash: no grants, ptr stays 1, prior broadcast still visible
        squash = 1'b1;
        set_req(0, 1'b1, 6'd9,  32'h90, 5'd5);
        set_req(1, 1'b1, 6'd13, 32'h91, 5'd6);
        #1 chk("sq_ready", 64'(fu_result_ready), 64'(4'b0000));
        chk("sq_prev_v",   64'(cdb_packet[0].valid),    64'(1'b1));
        chk("sq_prev_prn", 64'(cdb_packet[0].dest_prn), 64'd8);
        tick();
        lane_off("sq_l0", 0);
        lane_off("sq_l1", 1);
        squash = 1'b0;
        #1 chk("post_sq_ready", 64'(fu_result_ready), 64'(4'b0011));
        tick();
        clr_all();
        lane_on("post_sq_l0", 0, 6'd13, 32'h91, 5'd6);
        lane_on("post_sq_l1", 1, 6'd9,  32'h90, 5'd5);
        tick();
        lane_off("drain_l0", 0);
        lane_off("drain_l1", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
